// File: rtl/nn_bp_sequencer_if.sv
// Handshake and per-layer control bundle between the training top level and the delta sequencer.
// The master side is the sequencer; the slave side is the training controller that starts or aborts passes.
interface nn_bp_sequencer_if #(
  parameter int NL              = 3,
  parameter int STREAM_LEN_LOG2 = 8,
  parameter int LW              = 2
);
  logic                       start;
  logic                       hold;
  logic                       abort;
  logic                       busy;
  logic                       done;
  logic [NL-1:0]              layer_init;
  logic [NL-1:0]              layer_en;
  logic [NL-1:0]              update_en;
  logic [LW-1:0]              layer_idx;
  logic [STREAM_LEN_LOG2-1:0] run_cnt;

  modport master (
    input  start, hold, abort,
    output busy, done, layer_init, layer_en, update_en, layer_idx, run_cnt
  );

  modport slave (
    output start, hold, abort,
    input  busy, done, layer_init, layer_en, update_en, layer_idx, run_cnt
  );
endinterface

// File: rtl/nn_bp_sequencer.sv
// Backward-pass sequencer: per layer (output to input) clear, settle, accumulate one stream, update strobe.
// Every output is registered; hold freezes settle/run and masks the accumulate enable, abort returns to idle.
module nn_bp_sequencer #(
  parameter int NL              = 3,
  parameter int STREAM_LEN_LOG2 = 8,
  parameter int SETTLE          = 2,
  parameter int LW              = 2
) (
  input logic               clk,
  input logic               init,
  nn_bp_sequencer_if.master bus
);
  localparam int SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETTLE, S_RUN, S_UPDATE, S_FIN} state_t;

  state_t                     state;
  logic [SW-1:0]              settle_cnt;
  logic [STREAM_LEN_LOG2-1:0] run_cnt;
  logic [LW-1:0]              layer_idx;
  logic                       busy;
  logic                       done;
  logic [NL-1:0]              layer_init;
  logic [NL-1:0]              layer_en;
  logic [NL-1:0]              update_en;

  function automatic logic [NL-1:0] sel(input logic [LW-1:0] idx);
    return NL'(1) << idx;
  endfunction

  // Outputs are decoded from the state being entered, so they line up with that state's cycle.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      run_cnt    <= '0;
      layer_idx  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      layer_init <= '0;
      layer_en   <= '0;
      update_en  <= '0;
    end else begin
      done       <= 1'b0;
      layer_init <= '0;
      layer_en   <= '0;
      update_en  <= '0;
      if (state != S_IDLE && bus.abort) begin
        state      <= S_IDLE;
        settle_cnt <= '0;
        run_cnt    <= '0;
        layer_idx  <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state      <= S_CLEAR;
              busy       <= 1'b1;
              layer_idx  <= LW'(NL - 1);
              layer_init <= sel(LW'(NL - 1));
            end
          end
          S_CLEAR: begin
            if (SETTLE > 0) begin
              state      <= S_SETTLE;
              settle_cnt <= '0;
            end else begin
              state    <= S_RUN;
              run_cnt  <= '0;
              layer_en <= sel(layer_idx);
            end
          end
          S_SETTLE: begin
            if (!bus.hold) begin
              if (settle_cnt == SW'(SETTLE_LAST)) begin
                state    <= S_RUN;
                run_cnt  <= '0;
                layer_en <= sel(layer_idx);
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          S_RUN: begin
            // A held cycle keeps the count and leaves the enable low, so enabled cycles stay exact.
            if (!bus.hold) begin
              run_cnt <= run_cnt + 1'b1;
              if (&run_cnt) begin
                state     <= S_UPDATE;
                update_en <= sel(layer_idx);
              end else begin
                layer_en <= sel(layer_idx);
              end
            end
          end
          S_UPDATE: begin
            if (layer_idx == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state      <= S_CLEAR;
              layer_idx  <= layer_idx - 1'b1;
              layer_init <= sel(layer_idx - 1'b1);
            end
          end
          S_FIN: begin
            if (bus.start) begin
              state      <= S_CLEAR;
              layer_idx  <= LW'(NL - 1);
              layer_init <= sel(LW'(NL - 1));
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.layer_init = layer_init;
  assign bus.layer_en   = layer_en;
  assign bus.update_en  = update_en;
  assign bus.layer_idx  = layer_idx;
  assign bus.run_cnt    = run_cnt;
endmodule

// File: tb/tb_nn_bp_sequencer.sv
// Bench for nn_bp_sequencer: a step-list reference model scores one instance every cycle,
// with a vector table and directed sequences for reset, hold, abort, back-to-back and a SETTLE=0 variant.
module tb_nn_bp_sequencer;
  localparam int A_NL  = 2;
  localparam int A_LEN = 8;
  localparam int A_SET = 1;

  logic clk = 1'b0;
  logic init;
  int   checks = 0;
  int   failures = 0;
  int   cyc;

  always #5 clk = ~clk;

  nn_bp_sequencer_if #(.NL(2), .STREAM_LEN_LOG2(3), .LW(1)) ba ();
  nn_bp_sequencer_if #(.NL(1), .STREAM_LEN_LOG2(2), .LW(1)) bb ();

  nn_bp_sequencer #(.NL(2), .STREAM_LEN_LOG2(3), .SETTLE(1), .LW(1)) dut_a (.clk(clk), .init(init), .bus(ba));
  nn_bp_sequencer #(.NL(1), .STREAM_LEN_LOG2(2), .SETTLE(0), .LW(1)) dut_b (.clk(clk), .init(init), .bus(bb));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: a pass is a list of the cycles it will show, consumed one per unheld edge.
  typedef enum {K_CLEAR, K_SETTLE, K_RUN, K_UPDATE, K_FIN} kind_e;
  typedef struct {kind_e kind; int layer; int cnt;} step_t;
  step_t plan[$];
  bit    held;

  task automatic build_plan();
    int l;
    for (int j = 0; j < A_NL; j++) begin
      l = A_NL - 1 - j;
      plan.push_back('{K_CLEAR, l, 0});
      for (int s = 0; s < A_SET; s++) plan.push_back('{K_SETTLE, l, 0});
      for (int r = 0; r < A_LEN; r++) plan.push_back('{K_RUN, l, r});
      plan.push_back('{K_UPDATE, l, 0});
    end
    plan.push_back('{K_FIN, 0, 0});
  endtask

  always @(posedge clk or posedge init) begin
    if (init) begin
      plan.delete();
      held = 1'b0;
    end else if (plan.size() > 0 && ba.abort) begin
      plan.delete();
      held = 1'b0;
    end else if (plan.size() > 0 && (plan[0].kind == K_SETTLE || plan[0].kind == K_RUN) && ba.hold) begin
      held = 1'b1;
    end else begin
      held = 1'b0;
      if (plan.size() > 0) void'(plan.pop_front());
      if (plan.size() == 0 && ba.start) build_plan();
    end
  end

  function automatic logic [11:0] exp_a();
    logic [1:0] li, le, ue;
    logic [2:0] rc;
    logic       bz, dn, idx;
    step_t      s;
    li = '0; le = '0; ue = '0; rc = '0; bz = 1'b0; dn = 1'b0; idx = 1'b0;
    if (plan.size() > 0) begin
      s   = plan[0];
      bz  = 1'b1;
      idx = s.layer[0];
      case (s.kind)
        K_CLEAR:  li = 2'b01 << s.layer;
        K_RUN: begin
          rc = s.cnt[2:0];
          if (!held) le = 2'b01 << s.layer;
        end
        K_UPDATE: ue = 2'b01 << s.layer;
        K_FIN:    dn = 1'b1;
        default:  ;
      endcase
    end
    return {bz, dn, li, le, ue, idx, rc};
  endfunction

  function automatic logic [11:0] act_a();
    return {ba.busy, ba.done, ba.layer_init, ba.layer_en, ba.update_en, ba.layer_idx, ba.run_cnt};
  endfunction

  always @(negedge clk) begin
    logic ok;
    check("model_a", 32'(act_a()), 32'(exp_a()));
    ok = $onehot0(ba.layer_init) && $onehot0(ba.layer_en) && $onehot0(ba.update_en) &&
         ((int'(ba.layer_init != 0) + int'(ba.layer_en != 0) + int'(ba.update_en != 0)) <= 1);
    check("onehot_a", 32'(ok), 32'd1);
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (ba.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(ba.busy), 32'd0);
  endtask

  typedef struct {int cyc; logic [1:0] li; logic [1:0] le; logic [1:0] ue; logic dn; logic bz; logic idx; logic [2:0] rc;} vec_t;
  vec_t tbl[12];

  initial begin
    int   en1, done_cyc;
    logic saw_done, saw_ue0;

    tbl[0]  = '{1,  2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[1]  = '{2,  2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[2]  = '{3,  2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[3]  = '{6,  2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[4]  = '{10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 3'd7};
    tbl[5]  = '{11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[6]  = '{12, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{13, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[8]  = '{14, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[9]  = '{22, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[10] = '{23, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[11] = '{24, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0};

    init = 1'b0;
    ba.start = 1'b0; ba.hold = 1'b0; ba.abort = 1'b0;
    bb.start = 1'b0; bb.hold = 1'b0; bb.abort = 1'b0;
    #1 init = 1'b1;
    @(negedge clk);
    check("reset_a", 32'(act_a()), 32'd0);
    check("reset_b", 32'({bb.busy, bb.done, bb.layer_init, bb.layer_en, bb.update_en, bb.layer_idx, bb.run_cnt}), 32'd0);
    init = 1'b0;

    // Nominal pass against the vector table.
    @(negedge clk);
    ba.start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      ba.start = 1'b0;
      for (int i = 0; i < 12; i++)
        if (tbl[i].cyc == c)
          check($sformatf("nominal_c%0d", c), 32'(act_a()),
                32'({tbl[i].bz, tbl[i].dn, tbl[i].li, tbl[i].le, tbl[i].ue, tbl[i].idx, tbl[i].rc}));
    end

    // Asynchronous reset in the middle of RUN.
    ba.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      ba.start = 1'b0;
    end
    #2 init = 1'b1;
    #1 check("init_midrun", 32'(act_a()), 32'd0);
    @(negedge clk);
    init = 1'b0;
    repeat (5) @(negedge clk);
    check("init_stays_idle", 32'(act_a()), 32'd0);

    // Three hold cycles inside the first layer's RUN.
    ba.start = 1'b1;
    en1 = 0;
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ba.start = 1'b0;
      if (ba.layer_en == 2'b10) en1++;
      if (ba.done) done_cyc = c;
      if (c == 7) check("hold_en_low", 32'(ba.layer_en), 32'd0);
      ba.hold = (c >= 5 && c <= 7);
    end
    check("hold_en_cycles", 32'(en1), 32'd8);
    check("hold_done_cycle", 32'(done_cyc), 32'd26);

    // Abort during the second layer's SETTLE.
    ba.start = 1'b1;
    saw_done = 1'b0;
    saw_ue0 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      ba.start = 1'b0;
      saw_done |= ba.done;
      saw_ue0 |= ba.update_en[0];
      if (c == 14) check("abort_idle", 32'(act_a()), 32'd0);
      ba.abort = (c == 13);
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_no_upd0", 32'(saw_ue0), 32'd0);

    // Back-to-back passes with START held high.
    ba.start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 23) check("b2b_done", 32'(ba.done), 32'd1);
      if (c == 24) check("b2b_reclear", 32'({ba.busy, ba.layer_init}), 32'({1'b1, 2'b10}));
    end
    ba.start = 1'b0;
    wait_idle(60);

    // SETTLE=0 single-layer instance, with a START pulse during RUN.
    @(negedge clk);
    bb.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      logic       li, le, ue, dn, bz;
      logic [1:0] rc;
      @(negedge clk);
      bb.start = (c == 3);
      li = (c == 1);
      le = (c >= 2 && c <= 5);
      ue = (c == 6);
      dn = (c == 7);
      bz = (c <= 7);
      rc = le ? 2'(c - 2) : 2'd0;
      check($sformatf("short_c%0d", c), 32'({bb.busy, bb.done, bb.layer_init, bb.layer_en, bb.update_en, bb.run_cnt}),
            32'({bz, dn, li, le, ue, rc}));
    end

    // Randomized traffic; the model and one-hot checks score every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ba.start = ($urandom_range(0, 7) == 0);
      ba.hold  = ($urandom_range(0, 3) == 0);
      ba.abort = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    ba.start = 1'b0; ba.hold = 1'b0; ba.abort = 1'b0;
    wait_idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
